// File: rtl/mac_accum_ctrl_if.sv
// mac_accum_ctrl_if: job, operand-fetch, accumulator-control and result signals of mac_accum_ctrl.
// The abort input exists only when MAC_ACCUM_CTRL_ABORT_EN is defined.
interface mac_accum_ctrl_if;
    logic        start;
    logic [7:0]  vec_len;
    logic [4:0]  q_frac_in;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_idx;
    logic        acc_clr;
    logic        acc_en;
    logic [4:0]  q_frac;
    logic [15:0] norm_result;
    logic [15:0] result;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
`ifdef MAC_ACCUM_CTRL_ABORT_EN
    logic        abort;
    modport master (
        input  start, vec_len, q_frac_in, op_ready, norm_result, res_ready, abort,
        output op_valid, op_idx, acc_clr, acc_en, q_frac, result, res_valid, busy
    );
    modport slave (
        output start, vec_len, q_frac_in, op_ready, norm_result, res_ready, abort,
        input  op_valid, op_idx, acc_clr, acc_en, q_frac, result, res_valid, busy
    );
`else
    modport master (
        input  start, vec_len, q_frac_in, op_ready, norm_result, res_ready,
        output op_valid, op_idx, acc_clr, acc_en, q_frac, result, res_valid, busy
    );
    modport slave (
        output start, vec_len, q_frac_in, op_ready, norm_result, res_ready,
        input  op_valid, op_idx, acc_clr, acc_en, q_frac, result, res_valid, busy
    );
`endif
endinterface

// File: rtl/mac_accum_ctrl.sv
// mac_accum_ctrl: sequences a dot-product job (clear, operand issue, pipeline drain, normalize, hold result).
// Optional abort input enabled by MAC_ACCUM_CTRL_ABORT_EN.
module mac_accum_ctrl #(
    parameter int PIPE_LAT = 3,
    parameter int NORM_LAT = 1
) (
    input logic              clk,
    input logic              rst_n,
    mac_accum_ctrl_if.master bus
);
    localparam int NW = $clog2(NORM_LAT + 1);
    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, NORM, HOLD} state_t;
    state_t state, state_nxt;
    logic [7:0] len, cnt;
    logic [PIPE_LAT-1:0] sr, sr_nxt;
    logic [NW-1:0] ncnt;
    logic [15:0] res;
    logic [4:0] qf;
    logic xfer, norm_done, abort_hit;
    assign xfer      = bus.op_valid && bus.op_ready;
    assign sr_nxt    = (sr << 1) | PIPE_LAT'(xfer);
    assign norm_done = ncnt == NW'(NORM_LAT - 1);
`ifdef MAC_ACCUM_CTRL_ABORT_EN
    assign abort_hit = bus.abort && state inside {CLEAR, ISSUE, DRAIN, NORM};
`else
    assign abort_hit = 1'b0;
`endif
    assign bus.op_valid  = state == ISSUE;
    assign bus.op_idx    = cnt;
    assign bus.acc_clr   = state == CLEAR;
    assign bus.acc_en    = sr[PIPE_LAT-1];
    assign bus.q_frac    = qf;
    assign bus.result    = res;
    assign bus.res_valid = state == HOLD;
    assign bus.busy      = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // DRAIN leaves on the cycle whose shift makes the pipe empty, so NORM starts right after the last accumulate
    always_comb begin
        state_nxt = state;
        if (abort_hit) state_nxt = IDLE;
        else begin
            case (state)
                IDLE:    state_nxt = bus.start ? (bus.vec_len == 8'd0 ? HOLD : CLEAR) : IDLE;
                CLEAR:   state_nxt = ISSUE;
                ISSUE:   state_nxt = (xfer && cnt == len - 8'd1) ? DRAIN : ISSUE;
                DRAIN:   state_nxt = sr_nxt == '0 ? NORM : DRAIN;
                NORM:    state_nxt = norm_done ? HOLD : NORM;
                HOLD:    state_nxt = bus.res_ready ? IDLE : HOLD;
                default: state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len  <= '0;
            cnt  <= '0;
            sr   <= '0;
            ncnt <= '0;
            res  <= '0;
            qf   <= '0;
        end else begin
            sr   <= abort_hit ? '0 : sr_nxt;
            ncnt <= (state == NORM && !norm_done && !abort_hit) ? ncnt + 1'b1 : '0;
            if (state == IDLE && bus.start) begin
                len <= bus.vec_len;
                qf  <= bus.q_frac_in;
                cnt <= '0;
                if (bus.vec_len == 8'd0) res <= '0;
            end else if (xfer && !abort_hit) cnt <= cnt + 8'd1;
            if (state == NORM && norm_done && !abort_hit) res <= bus.norm_result;
        end
    end
endmodule
